// File: rtl/axi_pkg.sv
// Shared AXI encodings and bridge state constants for the data-side SRAM-like bridge.
package axi_pkg;

  localparam logic [1:0] BURST_INCR  = 2'b01;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] SIZE_BYTE   = 2'b00;
  localparam logic [1:0] SIZE_HALF   = 2'b01;
  localparam logic [1:0] SIZE_WORD   = 2'b10;

  localparam int unsigned STATE_W = 3;
  localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
  localparam logic [STATE_W-1:0] ST_RADDR = 3'd1;
  localparam logic [STATE_W-1:0] ST_RDATA = 3'd2;
  localparam logic [STATE_W-1:0] ST_WREQ  = 3'd3;
  localparam logic [STATE_W-1:0] ST_WRESP = 3'd4;

  // AXI beat size for a cache size code; the unused code 11 is treated as a word.
  function automatic logic [2:0] axi_wsize(input logic [1:0] size);
    return (size == 2'b11) ? 3'b010 : {1'b0, size};
  endfunction

endpackage

// File: rtl/wstrb_gen.sv
// Byte-lane write strobe from access size and the low address bits.
module wstrb_gen
  import axi_pkg::*;
(
  input  logic [1:0] size,
  input  logic [1:0] addr_lo,
  output logic [3:0] wstrb_c
);

  // Byte: one lane; half: upper or lower pair; word (and 11): all lanes.
  always_comb begin
    wstrb_c = 4'b0000;
    case (size)
      SIZE_BYTE: wstrb_c = 4'b0001 << addr_lo;
      SIZE_HALF: wstrb_c = addr_lo[1] ? 4'b1100 : 4'b0011;
      default:   wstrb_c = 4'b1111;
    endcase
  end

endmodule

// File: rtl/d_sram_axi_bridge.sv
// Data-side SRAM-like to AXI4 bridge: one single-beat transaction outstanding at a time.
module d_sram_axi_bridge
  import axi_pkg::*;
#(
  parameter int unsigned          ID_WIDTH = 4,
  parameter logic [ID_WIDTH-1:0]  AXI_ID   = ID_WIDTH'(1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                data_req,
  input  logic                data_wr,
  input  logic [1:0]          data_size,
  input  logic [31:0]         data_addr,
  input  logic [31:0]         data_wdata,
  output logic [31:0]         data_rdata,
  output logic                data_addr_ok,
  output logic                data_data_ok,
  output logic [ID_WIDTH-1:0] arid,
  output logic [31:0]         araddr,
  output logic [7:0]          arlen,
  output logic [2:0]          arsize,
  output logic [1:0]          arburst,
  output logic                arvalid,
  input  logic                arready,
  input  logic [ID_WIDTH-1:0] rid,
  input  logic [31:0]         rdata,
  input  logic [1:0]          rresp,
  input  logic                rlast,
  input  logic                rvalid,
  output logic                rready,
  output logic [ID_WIDTH-1:0] awid,
  output logic [31:0]         awaddr,
  output logic [7:0]          awlen,
  output logic [2:0]          awsize,
  output logic [1:0]          awburst,
  output logic                awvalid,
  input  logic                awready,
  output logic [ID_WIDTH-1:0] wid,
  output logic [31:0]         wdata,
  output logic [3:0]          wstrb,
  output logic                wlast,
  output logic                wvalid,
  input  logic                wready,
  input  logic [ID_WIDTH-1:0] bid,
  input  logic [1:0]          bresp,
  input  logic                bvalid,
  output logic                bready
);

  logic [STATE_W-1:0] state_q, state_d;
  logic               aw_done_q, aw_done_d;
  logic               w_done_q, w_done_d;
  logic               wr_q;
  logic [1:0]         size_q;
  logic [31:0]        addr_q;
  logic [31:0]        wdata_q;
  logic               unused_resp;

  // Responses and IDs are not inspected; completion is signalled regardless.
  assign unused_resp = ^{rid, rresp, bid, bresp};

  // Cache-side handshakes; suppressed during reset so an abandoned transaction never completes.
  assign data_addr_ok = ~rst & (state_q == ST_IDLE) & data_req;
  assign data_data_ok = ~rst & (((state_q == ST_RDATA) & rvalid & rlast) |
                                ((state_q == ST_WRESP) & bvalid));
  assign data_rdata   = (data_data_ok & ~wr_q) ? rdata : 32'h0;

  // AXI channel controls decoded from the state register and handshake flags.
  assign arvalid = (state_q == ST_RADDR);
  assign rready  = (state_q == ST_RDATA);
  assign awvalid = (state_q == ST_WREQ) & ~aw_done_q;
  assign wvalid  = (state_q == ST_WREQ) & ~w_done_q;
  assign bready  = (state_q == ST_WRESP);

  // Address/data payloads come straight from the latched request.
  assign arid    = AXI_ID;
  assign araddr  = addr_q;
  assign arlen   = 8'd0;
  assign arsize  = {1'b0, size_q};
  assign arburst = BURST_INCR;
  assign awid    = AXI_ID;
  assign awaddr  = addr_q;
  assign awlen   = 8'd0;
  assign awsize  = axi_wsize(size_q);
  assign awburst = BURST_INCR;
  assign wid     = AXI_ID;
  assign wdata   = wdata_q;
  assign wlast   = 1'b1;

  wstrb_gen u_wstrb_gen (
    .size    (size_q),
    .addr_lo (addr_q[1:0]),
    .wstrb_c (wstrb)
  );

  // State, handshake flags and request latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      wr_q      <= 1'b0;
      size_q    <= 2'b00;
      addr_q    <= 32'h0;
      wdata_q   <= 32'h0;
    end else begin
      state_q   <= state_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      if (data_addr_ok) begin
        wr_q    <= data_wr;
        size_q  <= data_size;
        addr_q  <= data_addr;
        wdata_q <= data_wdata;
      end
    end
  end

  // Next-state and write-handshake tracking.
  always_comb begin
    state_d   = state_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    case (state_q)
      ST_IDLE: begin
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        if (data_req) state_d = data_wr ? ST_WREQ : ST_RADDR;
      end
      ST_RADDR: if (arready) state_d = ST_RDATA;
      ST_RDATA: if (rvalid && rlast) state_d = ST_IDLE;
      ST_WREQ: begin
        if (awready) aw_done_d = 1'b1;
        if (wready)  w_done_d  = 1'b1;
        if (aw_done_d && w_done_d) state_d = ST_WRESP;
      end
      ST_WRESP: if (bvalid) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_d_sram_axi_bridge.sv
// Self-checking bench: directed scenarios plus randomized traffic against a transaction-level model.
module tb_d_sram_axi_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        data_addr_ok, data_data_ok;
  logic [3:0]  arid, rid, awid, wid, bid;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize;
  logic [1:0]  arburst, rresp, awburst, bresp;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [3:0]  wstrb;

  int checks = 0;
  int failures = 0;
  int n_ok = 0;
  int n_aok = 0;

  // Model: the one pending transaction and which AXI handshakes it has seen.
  logic        m_pend = 1'b0, m_wr = 1'b0, m_ar = 1'b0, m_aw = 1'b0, m_w = 1'b0;
  logic [1:0]  m_size = 2'b00;
  logic [31:0] m_addr = 32'h0, m_wdata = 32'h0;

  always #5 clk = ~clk;

  d_sram_axi_bridge dut (
    .clk(clk), .rst(rst),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
    .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
    .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Strobe from first principles: an aligned run of (1<<size) bytes covering addr.
  function automatic logic [3:0] model_strb(input logic [1:0] sz, input logic [31:0] a);
    int nb;
    int off;
    nb  = (sz == 2'b11) ? 4 : (1 << sz);
    off = (int'(a % 4) / nb) * nb;
    return 4'(((1 << nb) - 1) << off);
  endfunction

  // Compare all outputs mid-cycle, then advance the model across the clock edge.
  task automatic cycle();
    logic e_aok, e_arv, e_rr, e_awv, e_wv, e_br, e_ok;
    logic [31:0] e_rd;
    #1;
    e_aok = !rst && !m_pend && data_req;
    e_arv = m_pend && !m_wr && !m_ar;
    e_rr  = m_pend && !m_wr && m_ar;
    e_awv = m_pend && m_wr && !m_aw;
    e_wv  = m_pend && m_wr && !m_w;
    e_br  = m_pend && m_wr && m_aw && m_w;
    e_ok  = !rst && ((e_rr && rvalid && rlast) || (e_br && bvalid));
    e_rd  = (e_ok && e_rr) ? rdata : 32'h0;
    chk("addr_ok", 32'(data_addr_ok), 32'(e_aok));
    chk("arvalid", 32'(arvalid), 32'(e_arv));
    chk("rready",  32'(rready),  32'(e_rr));
    chk("awvalid", 32'(awvalid), 32'(e_awv));
    chk("wvalid",  32'(wvalid),  32'(e_wv));
    chk("bready",  32'(bready),  32'(e_br));
    chk("data_ok", 32'(data_data_ok), 32'(e_ok));
    chk("data_rdata", data_rdata, e_rd);
    if (e_arv) begin
      chk("araddr",  araddr, m_addr);
      chk("arsize",  32'(arsize), 32'({1'b0, m_size}));
      chk("arlen",   32'(arlen), 32'd0);
      chk("arburst", 32'(arburst), 32'd1);
      chk("arid",    32'(arid), 32'd1);
    end
    if (e_awv) begin
      chk("awaddr",  awaddr, m_addr);
      chk("awsize",  32'(awsize), (m_size == 2'b11) ? 32'd2 : 32'(m_size));
      chk("awlen",   32'(awlen), 32'd0);
      chk("awburst", 32'(awburst), 32'd1);
      chk("awid",    32'(awid), 32'd1);
    end
    if (e_wv) begin
      chk("wdata", wdata, m_wdata);
      chk("wstrb", 32'(wstrb), 32'(model_strb(m_size, m_addr)));
      chk("wlast", 32'(wlast), 32'd1);
      chk("wid",   32'(wid), 32'd1);
    end
    if (data_data_ok === 1'b1) n_ok++;
    if (data_addr_ok === 1'b1) n_aok++;
    @(posedge clk);
    if (rst) begin
      m_pend = 1'b0; m_ar = 1'b0; m_aw = 1'b0; m_w = 1'b0;
    end else if (!m_pend) begin
      if (data_req) begin
        m_pend = 1'b1; m_wr = data_wr; m_size = data_size;
        m_addr = data_addr; m_wdata = data_wdata;
        m_ar = 1'b0; m_aw = 1'b0; m_w = 1'b0;
      end
    end else if (!m_wr) begin
      if (!m_ar) begin
        if (arready) m_ar = 1'b1;
      end else if (rvalid && rlast) m_pend = 1'b0;
    end else begin
      if (m_aw && m_w) begin
        if (bvalid) m_pend = 1'b0;
      end else begin
        if (awready) m_aw = 1'b1;
        if (wready)  m_w  = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    data_req = 0; data_wr = 0; data_size = 0; data_addr = 0; data_wdata = 0;
    arready = 0; rvalid = 0; rlast = 0; rdata = 0; rid = 0; rresp = 0;
    awready = 0; wready = 0; bvalid = 0; bid = 0; bresp = 0;
  endtask

  task automatic req(input logic wr, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    data_req = 1; data_wr = wr; data_size = sz; data_addr = a; data_wdata = d;
  endtask

  initial begin
    int aok0, ok0;
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    cycle();
    rst = 1'b0;
    cycle();

    // Read, zero-wait.
    req(0, 2'b10, 32'h1000_0004, 32'h0);
    #1 chk("t_rd_addr_ok", 32'(data_addr_ok), 32'd1);
    cycle();
    data_req = 0; arready = 1;
    #1 chk("t_rd_araddr", araddr, 32'h1000_0004);
    chk("t_rd_arsize", 32'(arsize), 32'd2);
    chk("t_rd_arlen", 32'(arlen), 32'd0);
    cycle();
    arready = 0; rvalid = 1; rlast = 1; rdata = 32'hDEAD_BEEF;
    #1 chk("t_rd_data_ok", 32'(data_data_ok), 32'd1);
    chk("t_rd_rdata", data_rdata, 32'hDEAD_BEEF);
    cycle();
    rvalid = 0; rlast = 0;
    cycle();

    // Write byte to 0x2003.
    req(1, 2'b00, 32'h0000_2003, 32'hAA00_0000);
    cycle();
    data_req = 0; awready = 1; wready = 1;
    #1 chk("t_sb_wstrb", 32'(wstrb), 32'b1000);
    chk("t_sb_awsize", 32'(awsize), 32'd0);
    chk("t_sb_wlast", 32'(wlast), 32'd1);
    cycle();
    awready = 0; wready = 0;
    #1 chk("t_sb_no_ok_before_b", 32'(data_data_ok), 32'd0);
    cycle();
    bvalid = 1;
    #1 chk("t_sb_ok_on_b", 32'(data_data_ok), 32'd1);
    cycle();
    bvalid = 0;
    cycle();

    // Split AW/W: W accepted at once, AW held off for three cycles.
    ok0 = n_ok;
    req(1, 2'b10, 32'h0000_3000, 32'h1234_5678);
    cycle();
    data_req = 0; wready = 1;
    cycle();
    wready = 0;
    for (int i = 0; i < 2; i++) begin
      #1 chk("t_split_wvalid_low", 32'(wvalid), 32'd0);
      chk("t_split_awvalid_hold", 32'(awvalid), 32'd1);
      cycle();
    end
    awready = 1;
    #1 chk("t_split_bready_low", 32'(bready), 32'd0);
    cycle();
    awready = 0; bvalid = 1;
    #1 chk("t_split_bready", 32'(bready), 32'd1);
    cycle();
    bvalid = 0;
    cycle();
    chk("t_split_one_ok", 32'(n_ok - ok0), 32'd1);

    // Stalled read with data_req held high.
    aok0 = n_aok;
    req(0, 2'b10, 32'h0000_4000, 32'h0);
    cycle();
    data_addr = 32'h0000_5000;
    repeat (5) cycle();
    arready = 1;
    cycle();
    arready = 0; rvalid = 1; rlast = 1; rdata = 32'h0BAD_F00D;
    cycle();
    data_req = 0; rvalid = 0; rlast = 0;
    cycle();
    chk("t_stall_single_aok", 32'(n_aok - aok0), 32'd1);

    // Reset while waiting for B.
    req(1, 2'b10, 32'h0000_6000, 32'h5555_AAAA);
    cycle();
    data_req = 0; awready = 1; wready = 1;
    cycle();
    awready = 0; wready = 0; rst = 1; bvalid = 1;
    #1 chk("t_rst_no_ok", 32'(data_data_ok), 32'd0);
    cycle();
    rst = 0; bvalid = 0;
    #1 chk("t_rst_ctrl_idle", 32'({arvalid, rready, awvalid, wvalid, bready}), 32'd0);
    req(0, 2'b01, 32'h0000_7002, 32'h0);
    cycle();
    data_req = 0; arready = 1;
    cycle();
    arready = 0; rvalid = 1; rlast = 1; rdata = 32'hCAFE_0001;
    #1 chk("t_rst_read_ok", 32'(data_data_ok), 32'd1);
    cycle();
    rvalid = 0; rlast = 0;

    // Back-to-back: read, then half-word store to 0x0002 right after data_ok.
    req(0, 2'b10, 32'h0000_8000, 32'h0);
    cycle();
    data_req = 0; arready = 1;
    cycle();
    arready = 0; rvalid = 1; rlast = 1; rdata = 32'h1111_2222;
    req(1, 2'b01, 32'h0000_0002, 32'hBEEF_0000);
    #1 chk("t_b2b_aok_blocked", 32'(data_addr_ok), 32'd0);
    cycle();
    rvalid = 0; rlast = 0;
    #1 chk("t_b2b_second_aok", 32'(data_addr_ok), 32'd1);
    cycle();
    data_req = 0; awready = 1; wready = 1;
    #1 chk("t_b2b_wstrb", 32'(wstrb), 32'b1100);
    cycle();
    awready = 0; wready = 0; bvalid = 1;
    cycle();
    bvalid = 0;
    cycle();

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      rst        = ($urandom_range(199) == 0);
      data_req   = $urandom_range(1);
      data_wr    = $urandom_range(1);
      data_size  = 2'($urandom_range(3));
      data_addr  = $urandom;
      data_wdata = $urandom;
      arready    = $urandom_range(1);
      rvalid     = ($urandom_range(2) == 0);
      rlast      = ($urandom_range(3) != 0);
      rdata      = $urandom;
      rid        = 4'($urandom);
      rresp      = 2'($urandom);
      awready    = $urandom_range(1);
      wready     = $urandom_range(1);
      bvalid     = ($urandom_range(2) == 0);
      bid        = 4'($urandom);
      bresp      = 2'($urandom);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
